// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the FSM state encoding and
//   the derivation of the bit-counter width from the operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must be able to index bits 0..WIDTH-1; sizing it for
    // WIDTH+1 values also keeps it at least one bit wide for WIDTH=1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// half_adder / full_adder
//   Combinational one-bit adders used for the per-bit datapath of the serial
//   adder. full_adder is built from two half adders plus an OR of their
//   carries.
//   half_adder: a, b -> sum = a^b, carry = a&b
//   full_adder: a, b, cin -> sum = a^b^cin, carry = majority(a, b, cin)
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

    // The two half-adder carries can never both be 1, so OR gives majority.
    assign carry = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder computing a + b + cin one bit per clock, LSB first,
//   with valid/ready handshakes on both sides.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   a/b/cin valid        in_ready   accepting operands (IDLE)
//     a, b       WIDTH-bit addends    cin        carry-in
//     out_valid  result valid (DONE)  out_ready  consumer takes result
//     sum        a+b+cin bits WIDTH-1..0
//     carry      a+b+cin bit WIDTH
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH:0]   sum_cat;

    // Operands are shifted right each RUN cycle, so bit 0 is always the
    // bit currently being added.
    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New result bit enters at the MSB; after WIDTH shifts bit 0 lands at
    // the LSB. Concatenating keeps this legal for WIDTH=1.
    assign sum_cat = {fa_sum, sum_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_carry;
                sum_d = sum_cat[WIDTH:1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    carry_d = fa_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                // sum/carry are left untouched on the way back to IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
        end
    end

    // Handshake outputs depend on state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed, table-driven bench for serial_adder at WIDTH=8 and WIDTH=1,
//   plus hand-written sequences for back-to-back and mid-RUN reset cases.
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_carry;
        int         hold;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_sum;
        logic exp_carry;
    } vec1_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       iv8 = 1'b0, ir8, ci8 = 1'b0, ov8, or8 = 1'b1, co8;
    logic [7:0] a8 = '0, b8 = '0, s8;

    logic       iv1 = 1'b0, ir1, ci1 = 1'b0, ov1, or1 = 1'b1, co1;
    logic [0:0] a1 = '0, b1 = '0, s1;

    int checks = 0;
    int errors = 0;

    vec8_t t8[6];
    vec1_t t1[8];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(ci8), .out_valid(ov8), .out_ready(or8),
        .sum(s8), .carry(co8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .carry(co1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run8(input vec8_t v);
        int n;
        @(negedge clk);
        a8 = v.a; b8 = v.b; ci8 = v.cin; iv8 = 1'b1; or8 = (v.hold == 0);
        chk("in_ready8_idle", 64'(ir8), 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Disturb the inputs: latched operands must not change.
        iv8 = 1'b0; a8 = ~v.a; b8 = ~v.b; ci8 = ~v.cin;
        n = 0;
        while (!ov8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("latency8", 64'(n), 64'd8);
        chk("sum8", 64'(s8), 64'(v.exp_sum));
        chk("carry8", 64'(co8), 64'(v.exp_carry));
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid8", 64'(ov8), 64'd1);
            chk("hold_sum8", 64'(s8), 64'(v.exp_sum));
            chk("hold_carry8", 64'(co8), 64'(v.exp_carry));
        end
        or8 = 1'b1;
        @(negedge clk);
        chk("ret_idle8", 64'(ir8), 64'd1);
        chk("ret_novalid8", 64'(ov8), 64'd0);
        chk("ret_sum_kept8", 64'(s8), 64'(v.exp_sum));
        $display("W8  a=%02h b=%02h cin=%0d -> sum=%02h carry=%0d lat=%0d hold=%0d",
                 v.a, v.b, v.cin, s8, co8, n, v.hold);
    endtask

    task automatic run1(input vec1_t v);
        int n;
        @(negedge clk);
        a1 = v.a; b1 = v.b; ci1 = v.cin; iv1 = 1'b1; or1 = 1'b1;
        chk("in_ready1_idle", 64'(ir1), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency1", 64'(n), 64'd1);
        chk("sum1", 64'(s1), 64'(v.exp_sum));
        chk("carry1", 64'(co1), 64'(v.exp_carry));
        @(negedge clk);
        chk("ret_idle1", 64'(ir1), 64'd1);
        $display("W1  a=%0d b=%0d cin=%0d -> sum=%0d carry=%0d lat=%0d",
                 v.a, v.b, v.cin, s1, co1, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        t8[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        t8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
        t8[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0};
        t8[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 5};
        t8[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 0};
        t8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 2};

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready8", 64'(ir8), 64'd1);
        chk("rst_out_valid8", 64'(ov8), 64'd0);
        chk("rst_sum8", 64'(s8), 64'd0);
        chk("rst_carry8", 64'(co8), 64'd0);
        chk("rst_in_ready1", 64'(ir1), 64'd1);
        chk("rst_out_valid1", 64'(ov1), 64'd0);
        $display("reset: in_ready=%0d out_valid=%0d sum=%02h carry=%0d", ir8, ov8, s8, co8);

        for (int i = 0; i < 6; i++) run8(t8[i]);
        for (int i = 0; i < 8; i++) run1(t1[i]);

        // Back-to-back: second request raised during RUN must wait for IDLE,
        // and is accepted WIDTH+2 edges after the first.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0;
        n = 1;
        while (!ov8 && n < 30) begin
            chk("b2b_no_ready_run", 64'(ir8), 64'd0);
            @(negedge clk);
            n++;
        end
        chk("b2b_latency_a", 64'(n), 64'd8);
        chk("b2b_sum_a", 64'(s8), 64'h11);
        chk("b2b_carry_a", 64'(co8), 64'd0);
        $display("B2B first  sum=%02h carry=%0d lat=%0d", s8, co8, n);
        @(negedge clk);
        chk("b2b_idle", 64'(ir8), 64'd1);
        @(negedge clk);
        iv8 = 1'b0;
        chk("b2b_accepted", 64'(ir8), 64'd0);
        n = 0;
        while (!ov8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency_b", 64'(n), 64'd8);
        chk("b2b_sum_b", 64'(s8), 64'h33);
        chk("b2b_carry_b", 64'(co8), 64'd0);
        $display("B2B second sum=%02h carry=%0d lat=%0d", s8, co8, n);
        @(negedge clk);

        // Reset during RUN bit 3 discards the partial result.
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 64'(ir8), 64'd1);
        chk("midrst_out_valid", 64'(ov8), 64'd0);
        chk("midrst_sum", 64'(s8), 64'd0);
        chk("midrst_carry", 64'(co8), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov8) seen = 1;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        $display("mid-RUN reset: in_ready=%0d sum=%02h carry=%0d valid_seen=%0d", ir8, s8, co8, seen);
        run8('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
